instr_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control unit in the 32-bit single-cycle RISC-V core.
- Owns the program counter and drives the instruction memory through a ready-based handshake.
- Holds the fetched instruction stable for decode/execute until the core retires it.
- Computes the next PC from the control unit's 2-bit BRANCH code, the branch-taken flag, the immediate and the JALR target.

---
 rtl/rv_core_pkg.sv | 30 +++
 rtl/next_pc_calc.sv | 29 ++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared definitions for the single-cycle RV32 core: next-PC select codes,
// fetch FSM states, the canonical NOP and base opcodes used by decode.
package rv_core_pkg;

  // Next-PC select driven by the control unit
  localparam logic [1:0] BR_SEQ  = 2'b01;
  localparam logic [1:0] BR_JALR = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // RV32I base opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection plus 4-byte alignment check of the result.
module next_pc_calc
  import rv_core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  branch,
  input  logic        taken,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misalign
);

  assign pc_plus4 = pc + 32'd4;

  // Select the successor PC; 00 and any unknown code fall back to sequential
  always_comb begin
    next_pc = pc_plus4;
    case (branch)
      BR_JALR: next_pc = jalr_target & ~32'd1;
      BR_JUMP: next_pc = taken ? (pc + imm) : pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  assign misalign = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction per retire through a
// ready-based memory handshake and holds it stable until the core retires it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  BRANCH,
  input  logic        TAKEN,
  input  logic [31:0] IMM,
  input  logic [31:0] JALR_TARGET,
  input  logic        RETIRE,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_READY,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        INSTR_VALID,
  output logic        MISALIGN,
  output logic [31:0] RETIRE_COUNT
);
  import rv_core_pkg::*;

  // Memory handshake: IMEM_REQ/IMEM_ADDR are asserted in FETCH and held
  // constant until IMEM_READY is seen high on a rising edge; that edge
  // transfers IMEM_RDATA. No request is made while reset is active or on the
  // first edge after release, so a READY overlapping reset release is ignored.

  fetch_state_e state_q, state_d;
  logic         started_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         misalign_q;
  logic [31:0]  retire_cnt_q;

  logic [31:0]  npc;
  logic [31:0]  pc_plus4;
  logic         npc_misalign;
  logic         fetch_accept;
  logic         retire_fire;

  next_pc_calc u_next_pc (
    .pc          (pc_q),
    .branch      (BRANCH),
    .taken       (TAKEN),
    .imm         (IMM),
    .jalr_target (JALR_TARGET),
    .pc_plus4    (pc_plus4),
    .next_pc     (npc),
    .misalign    (npc_misalign)
  );

  assign fetch_accept = (state_q == ST_FETCH) && started_q && IMEM_READY;
  assign retire_fire  = (state_q == ST_EXEC) && RETIRE;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // FSM next-state: fetch until accepted, execute until retired, trap forever
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (fetch_accept) state_d = ST_EXEC;
      ST_EXEC:  if (RETIRE) state_d = npc_misalign ? ST_TRAP : ST_FETCH;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_FETCH;
    endcase
  end

  // FSM outputs: request only in an armed FETCH, expose instruction only in EXEC
  always_comb begin
    IMEM_REQ    = 1'b0;
    INSTR_VALID = 1'b0;
    INSTRUCTION = NOP_INSTR;
    case (state_q)
      ST_FETCH: IMEM_REQ = started_q;
      ST_EXEC: begin
        INSTR_VALID = 1'b1;
        INSTRUCTION = instr_q;
      end
      default: ;
    endcase
  end

  // Datapath: arm flag, PC, held instruction, sticky fault and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q    <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      misalign_q   <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      started_q <= 1'b1;
      if (fetch_accept) instr_q <= IMEM_RDATA;
      if (retire_fire) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
        if (npc_misalign) misalign_q <= 1'b1;
        else              pc_q       <= npc;
      end
    end
  end

  assign IMEM_ADDR    = pc_q;
  assign PC           = pc_q;
  assign PC_PLUS4     = pc_plus4;
  assign MISALIGN     = misalign_q;
  assign RETIRE_COUNT = retire_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a small instruction-memory model,
// expected fetch addresses queued when a retire is driven and popped when
// the unit issues its next request.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [1:0]  branch;
  logic        taken;
  logic [31:0] imm;
  logic [31:0] jalr_target;
  logic        retire;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] retire_count;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cnt_exp;
  logic [31:0] cur_pc;

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .BRANCH       (branch),
    .TAKEN        (taken),
    .IMM          (imm),
    .JALR_TARGET  (jalr_target),
    .RETIRE       (retire),
    .IMEM_RDATA   (imem_rdata),
    .IMEM_READY   (imem_ready),
    .IMEM_REQ     (imem_req),
    .IMEM_ADDR    (imem_addr),
    .INSTRUCTION  (instruction),
    .PC           (pc),
    .PC_PLUS4     (pc_plus4),
    .INSTR_VALID  (instr_valid),
    .MISALIGN     (misalign),
    .RETIRE_COUNT (retire_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Leave the inputs in a state that would misdirect the PC if sampled
  task automatic drive_garbage();
    branch      = 2'b10;
    taken       = 1'b1;
    imm         = 32'h0000_0002;
    jalr_target = 32'h0000_0102;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; serves one fetch with 'waits' wait states.
  task automatic do_fetch(input int waits);
    logic [31:0] exp_addr;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      exp_addr = imem_addr;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    for (int i = 0; i <= waits; i++) begin
      check("fetch_addr", imem_addr, exp_addr);
      check("fetch_req", {31'd0, imem_req}, 32'd1);
      check("fetch_valid", {31'd0, instr_valid}, 32'd0);
      check("fetch_instr", instruction, NOP);
      if (i == waits) begin
        retire     = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = mem_word(exp_addr);
      end else begin
        retire     = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    cur_pc = exp_addr;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_instr", instruction, mem_word(exp_addr));
    check("exec_pc", pc, exp_addr);
    check("exec_pc_plus4", pc_plus4, exp_addr + 32'd4);
    check("exec_req", {31'd0, imem_req}, 32'd0);
  endtask

  // Called at a negedge in EXEC; holds 'hold' cycles then retires.
  task automatic do_retire(input int hold, input logic [1:0] br, input logic tk,
                           input logic [31:0] im, input logic [31:0] jt,
                           input logic [31:0] exp_next, input bit exp_trap);
    for (int i = 0; i < hold; i++) begin
      retire = 1'b0;
      drive_garbage();
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instruction, mem_word(cur_pc));
      check("hold_count", retire_count, cnt_exp);
    end
    branch      = br;
    taken       = tk;
    imm         = im;
    jalr_target = jt;
    retire      = 1'b1;
    cnt_exp     = cnt_exp + 32'd1;
    if (!exp_trap) exp_q.push_back(exp_next);
    @(negedge clk);
    retire = 1'b0;
    drive_garbage();
    check("retire_count", retire_count, cnt_exp);
    check("post_valid", {31'd0, instr_valid}, 32'd0);
    check("post_instr", instruction, NOP);
    if (exp_trap) begin
      check("trap_misalign", {31'd0, misalign}, 32'd1);
      check("trap_req", {31'd0, imem_req}, 32'd0);
      check("trap_pc", pc, cur_pc);
    end else begin
      check("post_misalign", {31'd0, misalign}, 32'd0);
      check("post_req", {31'd0, imem_req}, 32'd1);
    end
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    retire     = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, RST_PC);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_count", retire_count, 32'd0);
    rst_n  = 1'b1;
    retire = 1'b0;
    cnt_exp = 32'd0;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    // Edge after release must ignore READY and only arm the request
    check("release_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    branch = 2'b01; taken = 1'b0; imm = 32'd0; jalr_target = 32'd0;
    retire = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    cnt_exp = 32'd0; cur_pc = 32'd0;
    @(negedge clk);
    apply_reset();

    // Sequential stream 0,4,8,12 then to 0x10
    do_fetch(0); do_retire(0, 2'b01, 1'b0, 32'd0, 32'd0, 32'h0000_0004, 1'b0);
    do_fetch(0); do_retire(0, 2'b00, 1'b0, 32'd0, 32'd0, 32'h0000_0008, 1'b0);
    do_fetch(0); do_retire(0, 2'b01, 1'b0, 32'd0, 32'd0, 32'h0000_000C, 1'b0);
    do_fetch(0); do_retire(0, 2'b01, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 1'b0);
    check("count_after_4", retire_count, 32'd4);

    // Three wait states at 0x10, then a taken forward jump to 0x20
    do_fetch(3); do_retire(2, 2'b11, 1'b1, 32'h0000_0010, 32'd0, 32'h0000_0020, 1'b0);

    // Taken backward branch, then back to 0x20, then not-taken
    do_fetch(1); do_retire(0, 2'b11, 1'b1, 32'hFFFF_FFF8, 32'd0, 32'h0000_0018, 1'b0);
    do_fetch(0); do_retire(0, 2'b11, 1'b1, 32'h0000_0008, 32'd0, 32'h0000_0020, 1'b0);
    do_fetch(0); do_retire(1, 2'b11, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'h0000_0024, 1'b0);

    // jalr clears bit 0, then jump to the top of the address space and wrap
    do_fetch(0); do_retire(0, 2'b10, 1'b0, 32'd0, 32'h0000_0105, 32'h0000_0104, 1'b0);
    do_fetch(2); do_retire(0, 2'b10, 1'b0, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0);
    do_fetch(0); do_retire(0, 2'b01, 1'b0, 32'd0, 32'd0, 32'h0000_0000, 1'b0);

    // Unknown select behaves as sequential
    do_fetch(0); do_retire(0, 2'bxx, 1'b1, 32'h0000_0040, 32'h0000_0200, 32'h0000_0004, 1'b0);

    // Retire counter wraps at 2^32
    do_fetch(0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    cnt_exp = 32'hFFFF_FFFF;
    check("count_preset", retire_count, 32'hFFFF_FFFF);
    do_retire(0, 2'b01, 1'b0, 32'd0, 32'd0, 32'h0000_0008, 1'b0);
    check("count_wrap", retire_count, 32'd0);

    // Asynchronous reset mid-EXEC with RETIRE high
    do_fetch(0);
    retire = 1'b1;
    branch = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", retire_count, 32'd0);
    check("async_pc", pc, RST_PC);
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("async_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    apply_reset();

    // jalr to a 2-byte aligned target traps and stays put
    do_fetch(0); do_retire(0, 2'b01, 1'b0, 32'd0, 32'd0, 32'h0000_0004, 1'b0);
    do_fetch(0); do_retire(0, 2'b10, 1'b0, 32'd0, 32'h0000_0102, 32'd0, 1'b1);
    imem_ready = 1'b1;
    retire     = 1'b1;
    repeat (4) @(negedge clk);
    check("trap_hold_req", {31'd0, imem_req}, 32'd0);
    check("trap_hold_misalign", {31'd0, misalign}, 32'd1);
    check("trap_hold_pc", pc, 32'h0000_0004);
    check("trap_hold_count", retire_count, cnt_exp);
    check("trap_hold_valid", {31'd0, instr_valid}, 32'd0);

    // Reset clears the trap; a misaligned branch offset also traps
    apply_reset();
    do_fetch(0); do_retire(0, 2'b11, 1'b1, 32'h0000_0002, 32'd0, 32'd0, 1'b1);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
